ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends one command byte to the keyboard,

---
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake and transfer status between a PS/2 host client and ps2_host_tx.
// A byte is taken on the rising clk edge where tx_valid & tx_ready; tx_data must be stable then.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;
  logic       err_noack;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_ok, err_timeout, err_noack
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_ok, err_timeout, err_noack
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data via pull-low enables.
// Define PS2_TX_RETRY_EN to retry a failed byte up to RETRY_MAX times before reporting.
module ps2_host_tx #(
  parameter int CLK_HZ      = 27000000,
  parameter int INHIBIT_US  = 100,
  parameter int START_TO_MS = 15,
  parameter int XFER_TO_MS  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int RETRY_MAX   = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_host_tx_if.slave      host,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe,
  output logic [3:0]        state_dbg
);
  localparam int INHIBIT_CYC = (CLK_HZ / 1000) * INHIBIT_US / 1000;
  localparam int START_CYC   = (CLK_HZ / 1000) * START_TO_MS;
  localparam int XFER_CYC    = (CLK_HZ / 1000) * XFER_TO_MS;
  localparam int TW          = $clog2(START_CYC);
  localparam int FW          = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TMR_MAX = {TW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_ACK,
    S_LINEWAIT, S_DONE, S_FAIL, S_RETRY
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic [FW-1:0]          flt_cnt;
  logic                   clk_filt, fe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // A new clock level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt  <= '0;
      clk_filt <= 1'b1;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt  <= '0;
        clk_filt <= clk_s;
        fe       <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  state_t        state, state_n;
  logic [7:0]    byte_q, byte_n;
  logic          parity_q, parity_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          data_oe_q, data_oe_n;
  logic          ack_q, ack_n, to_q, to_n, na_q, na_n;
  logic          fail, fail_to, xfer_exp;
`ifdef PS2_TX_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_cnt, retry_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_q    <= '0;
      parity_q  <= 1'b0;
      bitcnt    <= '0;
      tmr       <= '0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
      na_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      byte_q    <= byte_n;
      parity_q  <= parity_n;
      bitcnt    <= bitcnt_n;
      tmr       <= tmr_n;
      data_oe_q <= data_oe_n;
      ack_q     <= ack_n;
      to_q      <= to_n;
      na_q      <= na_n;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= retry_n;
`endif
    end
  end

  assign xfer_exp = (tmr >= TW'(XFER_CYC - 1));

  always_comb begin
    state_n   = state;
    byte_n    = byte_q;
    parity_n  = parity_q;
    bitcnt_n  = bitcnt;
    data_oe_n = data_oe_q;
    ack_n     = ack_q;
    to_n      = to_q;
    na_n      = na_q;
    tmr_n     = (tmr == TMR_MAX) ? tmr : tmr + 1'b1;
    fail      = 1'b0;
    fail_to   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n   = retry_cnt;
`endif
    case (state)
      S_IDLE: begin
        tmr_n = '0;
        if (host.tx_valid) begin
          byte_n   = host.tx_data;
          parity_n = ~^host.tx_data;
          ack_n    = 1'b0;
          to_n     = 1'b0;
          na_n     = 1'b0;
          state_n  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n  = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (tmr == TW'(INHIBIT_CYC - 1)) begin
          data_oe_n = 1'b1;
          tmr_n     = '0;
          state_n   = S_REQ;
        end
      end
      S_REQ: begin
        if (fe) begin
          data_oe_n = ~byte_q[0];
          bitcnt_n  = 4'd1;
          tmr_n     = '0;
          state_n   = S_DATA;
        end else if (tmr >= TW'(START_CYC - 1)) begin
          fail    = 1'b1;
          fail_to = 1'b1;
        end
      end
      S_DATA: begin
        if (xfer_exp) begin
          fail    = 1'b1;
          fail_to = 1'b1;
        end else if (fe) begin
          if (bitcnt == 4'd8) begin
            data_oe_n = ~parity_q;
            state_n   = S_PARITY;
          end else begin
            data_oe_n = ~byte_q[bitcnt[2:0]];
            bitcnt_n  = bitcnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (xfer_exp) begin
          fail    = 1'b1;
          fail_to = 1'b1;
        end else if (fe) begin
          data_oe_n = 1'b0;
          state_n   = S_ACK;
        end
      end
      S_ACK: begin
        if (xfer_exp) begin
          fail    = 1'b1;
          fail_to = 1'b1;
        end else if (fe) begin
          if (!data_s) state_n = S_LINEWAIT;
          else         fail    = 1'b1;
        end
      end
      S_LINEWAIT: begin
        if (xfer_exp) begin
          fail    = 1'b1;
          fail_to = 1'b1;
        end else if (clk_filt && data_s) begin
          ack_n   = 1'b1;
          state_n = S_DONE;
        end
      end
`ifdef PS2_TX_RETRY_EN
      S_RETRY: begin
        if (tmr == TW'(INHIBIT_CYC - 1)) begin
          tmr_n   = '0;
          state_n = S_INHIBIT;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Failures release the data line; the clock line is only ever pulled in INHIBIT.
    if (fail) begin
      data_oe_n = 1'b0;
      tmr_n     = '0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt < RW'(RETRY_MAX)) begin
        retry_n = retry_cnt + 1'b1;
        state_n = S_RETRY;
      end else
`endif
      begin
        to_n    = fail_to;
        na_n    = ~fail_to;
        state_n = S_FAIL;
      end
    end
  end

  assign ps2_clk_oe       = (state == S_INHIBIT);
  assign ps2_data_oe      = data_oe_q;
  assign host.tx_ready    = (state == S_IDLE);
  assign host.done        = (state == S_DONE) || (state == S_FAIL);
  assign host.busy        = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
  assign host.ack_ok      = ack_q;
  assign host.err_timeout = to_q;
  assign host.err_noack   = na_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a 12.5kHz device model on wired-AND lines checks each frame.
`timescale 1ns/100ps
module tb_ps2_host_tx;
  localparam int CLK_HZ      = 1000000;
  localparam int INHIBIT_CYC = 100;
  localparam int START_CYC   = 15000;
  localparam int HALF        = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if host();
  logic       ps2_clk_oe, ps2_data_oe;
  logic [3:0] state_dbg;
  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  logic       glitch = 1'b0;
  logic       glitch_on = 1'b0;
  wire        ps2_clk  = ~ps2_clk_oe & bfm_clk & ~glitch;
  wire        ps2_data = ~ps2_data_oe & bfm_data;

  ps2_host_tx #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard / monitors ----------------
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int acc_cnt = 0, acc_cyc = 0, prev_acc_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  logic [2:0] last_flags = 3'b000;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n && host.tx_valid && host.tx_ready) begin
      acc_cnt++;
      prev_acc_cyc = acc_cyc;
      acc_cyc = cyc_cnt;
    end
    if (rst_n && host.done) begin
      done_cnt++;
      done_cyc = cyc_cnt;
      last_flags = {host.ack_ok, host.err_timeout, host.err_noack};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [9:0] fr);
    exp_q.push_back(fr);
    host.tx_data  = b;
    host.tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (host.busy) break;
    end
    check("accept_busy", host.busy, 1'b1);
    check("accept_not_ready", host.tx_ready, 1'b0);
  endtask

  // mode 0: ACK, 1: no ACK, 2: never clock, 3: reset during bit 4
  task automatic bfm(input int mode, input bit drop_valid);
    int cnt;
    logic [9:0] got;
    logic [9:0] exp;
    cnt = 0;
    got = '0;
    for (int i = 0; i < 20000; i++) begin
      if (ps2_clk_oe) cnt++;
      else if (cnt > 0) break;
      cyc(1);
    end
    check("inhibit_len", cnt, INHIBIT_CYC);
    check("start_bit", ps2_data, 1'b0);
    if (drop_valid) host.tx_valid = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
    if (mode == 2) return;
    cyc(50);
    for (int b = 0; b < 10; b++) begin
      bfm_clk = 1'b0;
      cyc(HALF);
      if (mode == 3 && b == 4) begin
        check("pre_rst_data_oe", ps2_data_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_oe_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        bfm_clk = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        check("rst_tx_ready", host.tx_ready, 1'b1);
        check("rst_busy", host.busy, 1'b0);
        return;
      end
      bfm_clk = 1'b1;
      got[b] = ps2_data;
      cyc(HALF);
    end
    check("frame_byte", got[7:0], exp[7:0]);
    check("frame_parity", got[8], exp[8]);
    check("frame_stop", got[9], exp[9]);
    if (mode == 0) bfm_data = 1'b0;
    cyc(2);
    bfm_clk = 1'b0;
    cyc(HALF);
    bfm_clk = 1'b1;
    bfm_data = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, input int prev);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > prev) break;
      cyc(1);
    end
    check(tag, done_cnt, prev + 1);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] tbl_byte [4];
  logic [9:0] tbl_frame[4];
  int d, a;

  initial begin
    tbl_byte[0] = 8'h00; tbl_frame[0] = 10'b1_1_00000000;
    tbl_byte[1] = 8'h01; tbl_frame[1] = 10'b1_0_00000001;
    tbl_byte[2] = 8'hF4; tbl_frame[2] = 10'b1_0_11110100;
    tbl_byte[3] = 8'hFF; tbl_frame[3] = 10'b1_1_11111111;

    host.tx_valid = 1'b0;
    host.tx_data  = 8'h00;
    rst_n = 1'b0;
    cyc(5);
    check("rst_ready", host.tx_ready, 1'b1);
    check("rst_busy_done", {host.busy, host.done}, 2'b00);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_flags", {host.ack_ok, host.err_timeout, host.err_noack}, 3'b000);
    rst_n = 1'b1;
    cyc(20);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1
    d = done_cnt;
    send(8'hED, 10'b1_1_11101101);
    bfm(0, 1'b1);
    wait_done("ed_done", 300, d);
    check("ed_flags", last_flags, 3'b100);
    cyc(3);
    check("ed_single_done", done_cnt, d + 1);
    check("ed_ready", host.tx_ready, 1'b1);

    for (int k = 0; k < 4; k++) begin
      d = done_cnt;
      send(tbl_byte[k], tbl_frame[k]);
      bfm(0, 1'b1);
      wait_done("tbl_done", 300, d);
      check("tbl_flags", last_flags, 3'b100);
      cyc(5);
    end

    // Device leaves data high at the ACK edge
    d = done_cnt;
    send(8'hF4, 10'b1_0_11110100);
    bfm(1, 1'b1);
`ifdef PS2_TX_RETRY_EN
    repeat (2) begin
      check("retry_no_early_done", done_cnt, d);
      exp_q.push_back(10'b1_0_11110100);
      bfm(1, 1'b1);
    end
`endif
    wait_done("noack_done", 300, d);
    check("noack_flags", last_flags, 3'b001);
    cyc(5);

    // Device never clocks
    d = done_cnt;
    send(8'hFF, 10'b1_1_11111111);
    bfm(2, 1'b1);
    wait_done("to_done", 50000, d);
    check("to_flags", last_flags, 3'b010);
`ifndef PS2_TX_RETRY_EN
    check("to_latency", done_cyc - acc_cyc, INHIBIT_CYC + START_CYC + 1);
`endif
    cyc(1);
    check("to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("to_ready", host.tx_ready, 1'b1);
    cyc(5);

    // Reset in the middle of data bit 4 (0xED bit4 = 0, data pulled low)
    d = done_cnt;
    send(8'hED, 10'b1_1_11101101);
    bfm(3, 1'b1);
    cyc(20);
    check("rst_no_done", done_cnt, d);

    // tx_valid held across two frames with clock glitches
    d = done_cnt;
    a = acc_cnt;
    exp_q.push_back(10'b1_0_00000001);
    exp_q.push_back(10'b1_0_00000001);
    host.tx_data  = 8'h01;
    host.tx_valid = 1'b1;
    glitch_on = 1'b1;
    fork
      begin
        while (glitch_on) begin
          repeat ($urandom_range(10, 60)) @(posedge clk);
          @(negedge clk);
          #4.5 glitch = 1'b1;
          #1 glitch = 1'b0;
        end
      end
    join_none
    bfm(0, 1'b0);
    wait_done("hold_done1", 300, d);
    bfm(0, 1'b1);
    wait_done("hold_done2", 300, d + 1);
    glitch_on = 1'b0;
    cyc(200);
    check("hold_accepts", acc_cnt, a + 2);
    check("hold_dones", done_cnt, d + 2);
    check("hold_gap", (acc_cyc - prev_acc_cyc) > (INHIBIT_CYC + 20 * HALF), 1'b1);
    check("hold_flags", last_flags, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
